// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Default timing is 640x480@60 (25 MHz pixel clock from a 50 MHz system clock).
// The colour-bar table is consumed only when TEST_PATTERN_EN is defined.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 32'sd2;
    localparam int DEF_H_DISPLAY = 32'sd640;
    localparam int DEF_H_FP      = 32'sd16;
    localparam int DEF_H_SYNC    = 32'sd96;
    localparam int DEF_H_BP      = 32'sd48;
    localparam int DEF_V_DISPLAY = 32'sd480;
    localparam int DEF_V_FP      = 32'sd10;
    localparam int DEF_V_SYNC    = 32'sd2;
    localparam int DEF_V_BP      = 32'sd33;

    // Colour bars as {R,G,B} full-scale flags, index 0 (left) .. 7 (right):
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    // Total period of one axis (line or frame) in counts.
    function automatic int axis_total(input int display, input int fp,
                                      input int sync, input int bp);
        return display + fp + sync + bp;
    endfunction

    // Counter width able to hold 0 .. total-1, never narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total > 32'sd1) ? $clog2(total) : 32'sd1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible decode.
// Used once for the horizontal axis (ticked per pixel) and once for the
// vertical axis (ticked on each horizontal wrap).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter  int DISPLAY = DEF_H_DISPLAY,
    parameter  int FP      = DEF_H_FP,
    parameter  int SYNC    = DEF_H_SYNC,
    parameter  int BP      = DEF_H_BP,
    parameter  int POL     = 32'sd0,
    localparam int TOTAL   = axis_total(DISPLAY, FP, SYNC, BP),
    localparam int W       = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_raw,
    output logic         visible
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 32'sd1);
    localparam logic [W-1:0] SYNC_START = W'(DISPLAY + FP);
    localparam logic [W-1:0] SYNC_END   = W'(DISPLAY + FP + SYNC - 32'sd1);
    localparam logic [W-1:0] VIS_END    = W'(DISPLAY);
    localparam logic         ACT_LVL    = 1'(POL);

    logic [W-1:0] count_r;
    logic         in_sync_s;

    assign count     = count_r;
    assign wrap      = tick && (count_r == LAST);
    assign visible   = (count_r < VIS_END);
    assign in_sync_s = (count_r >= SYNC_START) && (count_r <= SYNC_END);
    // sync_raw already carries the configured polarity.
    assign sync_raw  = in_sync_s ? ACT_LVL : ~ACT_LVL;

    // Advance the position on each tick, wrapping TOTAL-1 back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (tick) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator for the pong display path.
// Divides the system clock down to a pixel tick, runs the horizontal and
// vertical counters, and registers sync/de/blanked colour one pixel tick
// behind pixel_x/pixel_y so they line up with the renderer's rgb_in.
// Optional macro TEST_PATTERN_EN adds pattern_sel and 8 vertical colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter  int CLK_DIV   = DEF_CLK_DIV,
    parameter  int H_DISPLAY = DEF_H_DISPLAY,
    parameter  int H_FP      = DEF_H_FP,
    parameter  int H_SYNC    = DEF_H_SYNC,
    parameter  int H_BP      = DEF_H_BP,
    parameter  int V_DISPLAY = DEF_V_DISPLAY,
    parameter  int V_FP      = DEF_V_FP,
    parameter  int V_SYNC    = DEF_V_SYNC,
    parameter  int V_BP      = DEF_V_BP,
    parameter  int H_POL     = 32'sd0,
    parameter  int V_POL     = 32'sd0,
    parameter  int RGB_W     = 32'sd12,
    localparam int H_TOTAL   = axis_total(H_DISPLAY, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = axis_total(V_DISPLAY, V_FP, V_SYNC, V_BP),
    localparam int XW        = cnt_width(H_TOTAL),
    localparam int YW        = cnt_width(V_TOTAL)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TEST_PATTERN_EN
    input  logic             pattern_sel,
`endif
    input  logic [RGB_W-1:0] rgb_in,
    output logic             Hsync,
    output logic             Vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             de,
    output logic [XW-1:0]    pixel_x,
    output logic [YW-1:0]    pixel_y,
    output logic             pix_ce,
    output logic             frame_start,
    output logic             vblank
);

    localparam int          DW       = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 32'sd1);
    localparam logic        H_ACT    = 1'(H_POL);
    localparam logic        V_ACT    = 1'(V_POL);

    logic [DW-1:0]    div_cnt_r;
    logic             pix_ce_r;
    logic             h_wrap_s, v_wrap_s;
    logic             h_sync_s, v_sync_s;
    logic             h_vis_s, v_vis_s;
    logic             de_s;
    logic [RGB_W-1:0] colour_s;
    logic             hsync_r, vsync_r, de_r, frame_start_r;
    logic [RGB_W-1:0] rgb_r;

    // Pixel-clock divider; the strobe is registered so it stays low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            pix_ce_r  <= 1'b0;
        end else begin
            pix_ce_r <= (div_cnt_r == DIV_LAST);
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .clk(clk), .rst(rst), .tick(pix_ce_r),
        .count(pixel_x), .wrap(h_wrap_s), .sync_raw(h_sync_s), .visible(h_vis_s)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .clk(clk), .rst(rst), .tick(h_wrap_s),
        .count(pixel_y), .wrap(v_wrap_s), .sync_raw(v_sync_s), .visible(v_vis_s)
    );

    assign de_s = h_vis_s && v_vis_s;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_DISPLAY / 32'sd8 > 32'sd0) ? (H_DISPLAY / 32'sd8) : 32'sd1;
    localparam int CH_W  = RGB_W / 32'sd3;

    logic [XW-1:0] bar_full_s;
    logic [2:0]    bar_idx_s;

    // Scale a 3-bit {R,G,B} flag set to full-scale channels of the colour bus.
    function automatic logic [RGB_W-1:0] expand_rgb3(input logic [2:0] c);
        return RGB_W'({{CH_W{c[2]}}, {CH_W{c[1]}}, {CH_W{c[0]}}});
    endfunction

    assign bar_full_s = pixel_x / XW'(BAR_W);
    assign bar_idx_s  = 3'(bar_full_s);

    // Choose between the renderer colour and the colour-bar pattern.
    always_comb begin
        colour_s = rgb_in;
        if (pattern_sel) begin
            colour_s = expand_rgb3(BAR_TABLE[bar_idx_s]);
        end else begin
            colour_s = rgb_in;
        end
    end
`else
    // Renderer colour passes straight to the blanking register.
    always_comb begin
        colour_s = rgb_in;
    end
`endif

    // Register sync/de/blanked colour from the current position on each tick,
    // and flag the tick that wraps the raster back to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r       <= ~H_ACT;
            vsync_r       <= ~V_ACT;
            de_r          <= 1'b0;
            rgb_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= h_wrap_s && v_wrap_s;
            if (pix_ce_r) begin
                hsync_r <= h_sync_s;
                vsync_r <= v_sync_s;
                de_r    <= de_s;
                rgb_r   <= de_s ? colour_s : '0;
            end
        end
    end

    assign Hsync       = hsync_r;
    assign Vsync       = vsync_r;
    assign de          = de_r;
    assign rgb         = rgb_r;
    assign pix_ce      = pix_ce_r;
    assign frame_start = frame_start_r;
    assign vblank      = ~v_vis_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using two small instances:
//   A: CLK_DIV=2, H 16/2/4/2 (24), V 4/1/2/1 (8), active-low syncs,
//      rgb_in = {4'hC, pixel_y, pixel_x} as a stand-in renderer.
//   B: CLK_DIV=1, H 4/1/2/1 (8), V 3/1/1/1 (6), active-high syncs, rgb_in=FFF.
// Edge numbers count posedges after reset release; instance A finishes its
// n-th pixel tick on edge 2n+1, instance B on edge n+1.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rgb_in_a, rgb_in_b;
    logic        hs_a, vs_a, de_a, pce_a, fs_a, vb_a;
    logic [11:0] rgb_a;
    logic [4:0]  x_a;
    logic [2:0]  y_a;
    logic        hs_b, vs_b, de_b, pce_b, fs_b, vb_b;
    logic [11:0] rgb_b;
    logic [2:0]  x_b, y_b;
`ifdef TEST_PATTERN_EN
    logic        psel_a, psel_b;
`endif

    int checks = 0;
    int errors = 0;
    int cur_edge = 0;

    always #5 clk = ~clk;

    assign rgb_in_a = {4'hC, y_a, x_a};
    assign rgb_in_b = 12'hFFF;

    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .RGB_W(12)
    ) dut_a (
        .clk(clk), .rst(rst),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel_a),
`endif
        .rgb_in(rgb_in_a), .Hsync(hs_a), .Vsync(vs_a), .rgb(rgb_a), .de(de_a),
        .pixel_x(x_a), .pixel_y(y_a), .pix_ce(pce_a), .frame_start(fs_a),
        .vblank(vb_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISPLAY(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .RGB_W(12)
    ) dut_b (
        .clk(clk), .rst(rst),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel_b),
`endif
        .rgb_in(rgb_in_b), .Hsync(hs_b), .Vsync(vs_b), .rgb(rgb_b), .de(de_b),
        .pixel_x(x_b), .pixel_y(y_b), .pix_ce(pce_b), .frame_start(fs_b),
        .vblank(vb_b)
    );

    typedef struct {
        int          edge_no;
        int          dut;
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        vb;
        logic        fs;
        logic [11:0] rgb;
    } vec_t;

    localparam int NV = 25;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after posedge number e (counted from reset release).
    task automatic goto_edge(input int e);
        bit moved = 1'b0;
        while (cur_edge < e) begin
            @(posedge clk);
            cur_edge++;
            moved = 1'b1;
        end
        if (moved) #1;
    endtask

    task automatic check_vec(input int i);
        vec_t v = vec[i];
        if (v.dut == 0) begin
            check($sformatf("v%0d A x", i),     x_a,   v.x);
            check($sformatf("v%0d A y", i),     y_a,   v.y);
            check($sformatf("v%0d A hsync", i), hs_a,  v.hs);
            check($sformatf("v%0d A vsync", i), vs_a,  v.vs);
            check($sformatf("v%0d A de", i),    de_a,  v.de);
            check($sformatf("v%0d A vblank", i), vb_a, v.vb);
            check($sformatf("v%0d A fstart", i), fs_a, v.fs);
            check($sformatf("v%0d A rgb", i),   rgb_a, v.rgb);
        end else begin
            check($sformatf("v%0d B x", i),     x_b,   v.x);
            check($sformatf("v%0d B y", i),     y_b,   v.y);
            check($sformatf("v%0d B hsync", i), hs_b,  v.hs);
            check($sformatf("v%0d B vsync", i), vs_b,  v.vs);
            check($sformatf("v%0d B de", i),    de_b,  v.de);
            check($sformatf("v%0d B vblank", i), vb_b, v.vb);
            check($sformatf("v%0d B fstart", i), fs_b, v.fs);
            check($sformatf("v%0d B rgb", i),   rgb_b, v.rgb);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " A x"}, x_a, 0);
        check({tag, " A y"}, y_a, 0);
        check({tag, " A hsync"}, hs_a, 1);
        check({tag, " A vsync"}, vs_a, 1);
        check({tag, " A de"}, de_a, 0);
        check({tag, " A rgb"}, rgb_a, 0);
        check({tag, " A fstart"}, fs_a, 0);
        check({tag, " A pix_ce"}, pce_a, 0);
        check({tag, " A vblank"}, vb_a, 0);
        check({tag, " B hsync"}, hs_b, 0);
        check({tag, " B vsync"}, vs_b, 0);
        check({tag, " B pix_ce"}, pce_b, 0);
        check({tag, " B rgb"}, rgb_b, 0);
    endtask

    // Watchdog: the whole run is a few thousand clocks.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fs_cnt;
        int b_low;

        //          edge dut  x   y  hs    vs    de    vb    fs    rgb
        vec[0]  = '{  3, 0,  1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC00};
        vec[1]  = '{  5, 1,  4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF};
        vec[2]  = '{  6, 1,  5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[3]  = '{  7, 1,  6, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[4]  = '{  8, 1,  7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[5]  = '{  9, 1,  0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[6]  = '{ 13, 0,  6, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC05};
        vec[7]  = '{ 26, 1,  1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[8]  = '{ 33, 0, 16, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC0F};
        vec[9]  = '{ 34, 1,  1, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[10] = '{ 35, 0, 17, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[11] = '{ 39, 0, 19, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[12] = '{ 42, 1,  1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[13] = '{ 45, 0, 22, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[14] = '{ 47, 0, 23, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[15] = '{ 49, 0,  0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vec[16] = '{ 49, 1,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vec[17] = '{ 51, 0,  1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC20};
        vec[18] = '{177, 0, 16, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC6F};
        vec[19] = '{195, 0,  1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[20] = '{243, 0,  1, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[21] = '{337, 0,  0, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[22] = '{339, 0,  1, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
        vec[23] = '{385, 0,  0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        vec[24] = '{387, 0,  1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC00};

`ifdef TEST_PATTERN_EN
        psel_a = 1'b0;
        psel_b = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");

        @(negedge clk);
        rst = 1'b0;
        cur_edge = 0;

        // Divider start-up: A strobes on every second clock, B on every clock.
        goto_edge(1);
        check("start A pix_ce e1", pce_a, 0);
        check("start B pix_ce e1", pce_b, 1);
        goto_edge(2);
        check("start A pix_ce e2", pce_a, 1);
        check("start B pix_ce e2", pce_b, 1);

        for (int i = 0; i < NV; i++) begin
            goto_edge(vec[i].edge_no);
            check_vec(i);
        end

        // Mid-frame asynchronous reset while A shows a visible pixel.
        goto_edge(491);
        check("pre-reset A x", x_a, 5);
        check("pre-reset A y", y_a, 2);
        check("pre-reset A de", de_a, 1);
        check("pre-reset A rgb", rgb_a, 12'hC44);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur_edge = 0;

        goto_edge(3);
        check("restart A x", x_a, 1);
        check("restart A y", y_a, 0);
        check("restart A de", de_a, 1);
        check("restart A rgb", rgb_a, 12'hC00);

        // No frame_start before the first wrap, then one every 384 clocks.
        fs_cnt = 0;
        b_low  = 0;
        for (int e = 4; e <= 384; e++) begin
            goto_edge(e);
            if (fs_a) fs_cnt++;
            if (!pce_b) b_low++;
        end
        check("no early frame_start", fs_cnt, 0);
        goto_edge(385);
        check("first frame_start", fs_a, 1);
        check("first wrap x", x_a, 0);
        check("first wrap y", y_a, 0);
        fs_cnt = 0;
        for (int e = 386; e <= 768; e++) begin
            goto_edge(e);
            if (fs_a) fs_cnt++;
            if (!pce_b) b_low++;
        end
        check("frame_start gap", fs_cnt, 0);
        goto_edge(769);
        check("second frame_start", fs_a, 1);
        check("B pix_ce low count", b_low, 0);

`ifdef TEST_PATTERN_EN
        psel_a = 1'b1;
        goto_edge(771);
        check("bar x0 white", rgb_a, 12'hFFF);
        goto_edge(772);
        check("bar hold", rgb_a, 12'hFFF);
        goto_edge(777);
        check("bar x3 yellow", rgb_a, 12'hFF0);
        goto_edge(785);
        check("bar x7 green", rgb_a, 12'h0F0);
        goto_edge(801);
        check("bar x15 de", de_a, 1);
        check("bar x15 black", rgb_a, 12'h000);
        goto_edge(817);
        psel_a = 1'b0;
        goto_edge(819);
        check("pattern off rgb_in", rgb_a, 12'hC20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator for the pong display path. It generates a pixel-clock enable from the system clock and runs horizontal and vertical counters. From these it produces sync pulses with configurable polarity, data-enable, pixel coordinates and frame/line strobes. It blanks the game-logic colour input outside the visible area. It sits between the game-object renderer (which consumes pixel_x/pixel_y and drives rgb_in) and the VGA connector.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 2 gives 25 MHz from 50 MHz
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, Hsync active level (0 = active-low)
V_POL, 0, Vsync active level
RGB_W, 12, colour bus width

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous reset, active-high
rgb_in  in  RGB_W  colour for (pixel_x, pixel_y) from renderer, combinational from those coordinates
Hsync  out  1  horizontal sync, polarity H_POL
Vsync  out  1  vertical sync, polarity V_POL
rgb  out  RGB_W  blanked colour to DAC
de  out  1  data enable, aligned with Hsync/Vsync/rgb
pixel_x  out  clog2(H_TOTAL)  current horizontal count
pixel_y  out  clog2(V_TOTAL)  current vertical count
pix_ce  out  1  one-clk pixel tick strobe
frame_start  out  1  one-clk pulse at start of each frame
vblank  out  1  high while pixel_y >= V_DISPLAY

Behaviour:
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_* parameters.
- Divider div_cnt runs 0..CLK_DIV-1. pix_ce=1 when div_cnt==CLK_DIV-1. CLK_DIV=1 gives pix_ce constantly high after reset.
- On pix_ce: pixel_x increments. It wraps H_TOTAL-1 -> 0. pixel_y increments on that wrap and wraps V_TOTAL-1 -> 0. Counts never reach H_TOTAL or V_TOTAL.
- Hsync is active while pixel_x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]. Vsync follows the same rule with the V_* parameters.
- de = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
- Hsync, Vsync, de and rgb are registered from the counter values on pix_ce. They therefore lag pixel_x/pixel_y by exactly one pixel tick, which aligns them with the combinational rgb_in.
- rgb = de ? rgb_in : 0.
- Outputs hold between pix_ce ticks.
- frame_start is a one-clk pulse in the clk cycle after the pix_ce on which the counters wrap to (0,0).
- Reset (async, mid-frame included): div_cnt, pixel_x and pixel_y are 0. Hsync = ~H_POL and Vsync = ~V_POL (inactive). de, rgb, frame_start and pix_ce are 0, and vblank is 0.
- After reset deasserts, the first pix_ce occurs CLK_DIV clks later.
- No frame_start is generated for the post-reset frame. The first frame_start occurs at the first wrap.

Optional Feature:
TEST_PATTERN_EN:
- Defined: adds input pattern_sel (1 bit). When pattern_sel=1, rgb_in is ignored and 8 vertical colour bars are output, each H_DISPLAY/8 wide.
- Bar index = pixel_x / (H_DISPLAY/8). Colour is a fixed table: white, yellow, cyan, green, magenta, red, blue, black (full-scale per channel).
- Blanking and latency rules are unchanged.
- Undefined: no pattern_sel port and no pattern logic.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL computation function
  - colour-bar table constants
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters DISPLAY, FP, SYNC, BP, POL
  - inputs: tick (count enable); outputs: count, wrap, sync_raw, visible

Test Plan:
- Default params, 50 MHz clk: pix_ce every 2 clks; line period 800 ticks = 1600 clks; Hsync low for pixel_x 656..751 (96 ticks), observed one tick late.
- Default params: Vsync low exactly on lines 490-491. Frame = 525 lines = 420000 ticks. frame_start pulses spaced 840000 clks.
- rgb_in=12'hFFF constant: rgb=FFF only while de=1 (640x480 per frame). rgb=0 in all porch and sync regions. Count 307200 non-zero pixels per frame.
- CLK_DIV=1, tiny timing (4/1/2/1, 3/1/1/1), H_POL=V_POL=1: verify pix_ce always high, Hsync high for x=5..6, wrap 7->0, Vsync high on line 4.
- Assert rst at pixel (300,200) for 3 clks: all outputs are at reset values immediately (async). Counting restarts from (0,0). No frame_start until the first wrap.
- TEST_PATTERN_EN defined, pattern_sel=1: rgb at visible x=0 is FFF, x=80 is FF0, x=639 is 000. Setting pattern_sel=0 restores rgb_in on the next tick.
